// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter_if
// Brief   : Write-back bus between the ALU/load requesters and the
//           register-file write arbiter, plus the arbiter's status outputs.
// Revision: 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  q_count;
  logic [15:0] stall_cnt;

  // Requester / observer side.
  modport master (
    output alu_valid, alu_rd, alu_result,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  rf_we, rf_waddr, rf_wdata, q_count, stall_cnt
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output rf_we, rf_waddr, rf_wdata, q_count, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter
// Brief   : Arbitrates the single register-file write port between an ALU
//           write-back stream (buffered in a DEPTH-entry FIFO) and an
//           unbuffered load write-back. Loads win unless the FIFO is full, in
//           which case the FIFO head drains so ALU results always progress.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_write_arbiter_if.slave bus
);

  localparam int              PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      c_depth     = 4'(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [15:0]     c_stall_max = 16'hFFFF;

  // FIFO storage: destination register and data per entry.
  logic [4:0]       r_q_rd   [DEPTH];
  logic [31:0]      r_q_data [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [3:0]       r_count;

  logic             r_rf_we;
  logic [4:0]       r_rf_waddr;
  logic [31:0]      r_rf_wdata;
  logic [15:0]      r_stall_cnt;

  logic             w_not_full;
  logic             w_push;
  logic             w_mem_grant;
  logic             w_pop;
  logic             w_grant;
  logic [4:0]       w_grant_rd;
  logic [31:0]      w_grant_data;
  logic             w_mem_stall;

  // Handshake and grant selection; readiness depends on occupancy only.
  always_comb begin
    w_not_full   = (r_count < c_depth);
    w_push       = bus.alu_valid & w_not_full;
    w_mem_grant  = bus.mem_valid & w_not_full;
    w_pop        = !w_mem_grant && (r_count != 4'd0);
    w_grant      = w_mem_grant | w_pop;
    w_mem_stall  = bus.mem_valid & !w_not_full;
    w_grant_rd   = r_q_rd[r_rd_ptr];
    w_grant_data = r_q_data[r_rd_ptr];
    if (w_mem_grant) begin
      w_grant_rd   = bus.mem_rd;
      w_grant_data = bus.mem_data;
    end
  end

  assign bus.alu_ready = w_not_full;
  assign bus.mem_ready = w_not_full;
  assign bus.rf_we     = r_rf_we;
  assign bus.rf_waddr  = r_rf_waddr;
  assign bus.rf_wdata  = r_rf_wdata;
  assign bus.q_count   = r_count;
  assign bus.stall_cnt = r_stall_cnt;

  // FIFO payload write; contents are only meaningful while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wr_ptr]   <= bus.alu_rd;
      r_q_data[r_wr_ptr] <= bus.alu_result;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Register-file write port; x0 writes consume the grant but never enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 32'd0;
    end else if (w_grant) begin
      r_rf_we    <= (w_grant_rd != 5'd0);
      r_rf_waddr <= w_grant_rd;
      r_rf_wdata <= w_grant_data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  // Saturating count of cycles in which a load was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (w_mem_stall && (r_stall_cnt != c_stall_max)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_write_arbiter
// Brief   : Directed, table-driven bench for regfile_write_arbiter (DEPTH=2)
//           with hand sequences for reset and stall-counter saturation.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ares;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        e_rdy;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_q;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    bus.alu_valid  = av;
    bus.alu_rd     = ard;
    bus.alu_result = ares;
    bus.mem_valid  = mv;
    bus.mem_rd     = mrd;
    bus.mem_data   = mdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;

    //            av ard   ares           mv mrd    mdat          rdy we waddr  wdata          q     stall
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 4'd0, 16'd0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 4'd0, 16'd0};
    vecs[2]  = '{1'b1, 5'd3, 32'd15,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 4'd1, 16'd0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd3,  32'd15,       4'd0, 16'd0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd3,  32'd15,       4'd0, 16'd0};
    vecs[5]  = '{1'b1, 5'd0, 32'd7,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd3,  32'd15,       4'd1, 16'd0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  32'd7,        4'd0, 16'd0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  32'd7,        4'd0, 16'd0};
    vecs[8]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd10, 32'hA0,       1'b1, 1'b1, 5'd10, 32'hA0,       4'd1, 16'd0};
    vecs[9]  = '{1'b1, 5'd2, 32'h22,       1'b1, 5'd11, 32'hA1,       1'b1, 1'b1, 5'd11, 32'hA1,       4'd2, 16'd0};
    vecs[10] = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd12, 32'hBAD,      1'b0, 1'b1, 5'd1,  32'h11,       4'd1, 16'd1};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'hA2,       1'b1, 1'b1, 5'd12, 32'hA2,       4'd1, 16'd1};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd2,  32'h22,       4'd0, 16'd1};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd2,  32'h22,       4'd0, 16'd1};
    vecs[14] = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd2,  32'h22,       4'd1, 16'd1};
    vecs[15] = '{1'b1, 5'd5, 32'h55,       1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd4,  32'h44,       4'd1, 16'd1};
    vecs[16] = '{1'b1, 5'd6, 32'h66,       1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd5,  32'h55,       4'd1, 16'd1};
    vecs[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd6,  32'h66,       4'd0, 16'd1};
    vecs[18] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd6,  32'h66,       4'd0, 16'd1};

    // Reset held across edges with requests present: nothing recorded.
    rst_n = 1'b0;
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 32'h77);
    tick();
    tick();
    chk("rst.alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("rst.mem_ready", {31'd0, bus.mem_ready}, 32'd1);
    chk("rst.rf_we",     {31'd0, bus.rf_we},     32'd0);
    chk("rst.rf_waddr",  {27'd0, bus.rf_waddr},  32'd0);
    chk("rst.rf_wdata",  bus.rf_wdata,           32'd0);
    chk("rst.q_count",   {28'd0, bus.q_count},   32'd0);
    chk("rst.stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    rst_n = 1'b1;

    // Table vectors; vector 0 is the first edge after reset release.
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].ares, vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
      chk($sformatf("v%0d.alu_ready", i), {31'd0, bus.alu_ready}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d.mem_ready", i), {31'd0, bus.mem_ready}, {31'd0, vecs[i].e_rdy});
      tick();
      chk($sformatf("v%0d.rf_we", i),     {31'd0, bus.rf_we},     {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d.rf_waddr", i),  {27'd0, bus.rf_waddr},  {27'd0, vecs[i].e_waddr});
      chk($sformatf("v%0d.rf_wdata", i),  bus.rf_wdata,           vecs[i].e_wdata);
      chk($sformatf("v%0d.q_count", i),   {28'd0, bus.q_count},   {28'd0, vecs[i].e_q});
      chk($sformatf("v%0d.stall_cnt", i), {16'd0, bus.stall_cnt}, {16'd0, vecs[i].e_stall});
    end

    // Queue two ALU entries, then reset between edges.
    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
    tick();
    chk("mid.q1", {28'd0, bus.q_count}, 32'd1);
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd13, 32'hA3);
    tick();
    chk("mid.q2",    {28'd0, bus.q_count}, 32'd2);
    chk("mid.we",    {31'd0, bus.rf_we},   32'd1);
    chk("mid.waddr", {27'd0, bus.rf_waddr}, 32'd13);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.rst.q_count",   {28'd0, bus.q_count},   32'd0);
    chk("mid.rst.rf_we",     {31'd0, bus.rf_we},     32'd0);
    chk("mid.rst.rf_waddr",  {27'd0, bus.rf_waddr},  32'd0);
    chk("mid.rst.rf_wdata",  bus.rf_wdata,           32'd0);
    chk("mid.rst.stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
    chk("mid.rst.alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post%0d.rf_we", i),   {31'd0, bus.rf_we},   32'd0);
      chk($sformatf("post%0d.q_count", i), {28'd0, bus.q_count}, 32'd0);
    end

    // Continuous contention: refusals occur on every other cycle once full.
    drive(1'b1, 5'd20, 32'h1234, 1'b1, 5'd21, 32'h5678);
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    chk("cont.stall_cnt", {16'd0, bus.stall_cnt}, 32'd4);
    chk("cont.q_count",   {28'd0, bus.q_count},   32'd2);

    // Preload the counter near its ceiling and keep refusing loads.
    force dut.r_stall_cnt = 16'hFFF0;
    #1;
    release dut.r_stall_cnt;
    for (int i = 0; i < 60; i++) begin
      tick();
    end
    chk("sat.stall_cnt", {16'd0, bus.stall_cnt}, 32'h0000FFFF);
    tick();
    tick();
    chk("sat.hold", {16'd0, bus.stall_cnt}, 32'h0000FFFF);

    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set ALU result queue depth (power of two, 2..8).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 alu_valid  input  1  SHALL mean ALU write-back request present.
REQ-005 alu_ready  output  1  SHALL mean ALU request accepted this cycle if alu_valid.
REQ-006 alu_rd  input  5  SHALL be ALU destination register.
REQ-007 alu_result  input  32  SHALL be ALU write data.
REQ-008 mem_valid  input  1  SHALL mean load write-back request present.
REQ-009 mem_ready  output  1  SHALL mean load request accepted this cycle if mem_valid.
REQ-010 mem_rd  input  5  SHALL be load destination register.
REQ-011 mem_data  input  32  SHALL be load write data.
REQ-012 rf_we  output  1  SHALL be register-file write enable (registered).
REQ-013 rf_waddr  output  5  SHALL be register-file write address (registered).
REQ-014 rf_wdata  output  32  SHALL be register-file write data (registered).
REQ-015 q_count  output  4  SHALL be current ALU queue occupancy, 0..DEPTH.
REQ-016 stall_cnt  output  16  SHALL count cycles a load request was refused.

Function
REQ-017 ALU requests SHALL enter a DEPTH-entry FIFO; alu_ready = (q_count < DEPTH), combinational from state only.
REQ-018 ALU transfer SHALL occur on alu_valid & alu_ready; entry {alu_rd, alu_result} pushed at that edge.
REQ-019 Load requests SHALL not be queued; mem_ready = (q_count < DEPTH).
REQ-020 Grant per cycle: if mem_valid & mem_ready -> load wins; else if q_count > 0 -> FIFO head wins; else no grant.
REQ-021 Exactly one grant max per cycle; granted FIFO head SHALL pop at same edge.
REQ-022 On a grant, next edge SHALL set rf_waddr/rf_wdata to the granted rd/data and rf_we = (rd != 0).
REQ-023 Without a grant, next edge SHALL set rf_we = 0; rf_waddr/rf_wdata SHALL hold previous values.
REQ-024 rd = 0 requests SHALL complete the handshake and consume a grant but never assert rf_we.
REQ-025 Latency: load accepted at edge N -> rf_we high after edge N (1 cycle); ALU pushed at edge N -> rf_we earliest after edge N+1 (2 cycles).
REQ-026 FIFO full (q_count = DEPTH): alu_ready = 0, mem_ready = 0, head SHALL be granted; guarantees ALU forward progress.
REQ-027 Simultaneous push and pop SHALL leave q_count unchanged; push-only +1, pop-only -1.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; order of ALU writes SHALL be preserved.
REQ-029 stall_cnt SHALL increment each cycle mem_valid & !mem_ready, saturating at 16'hFFFF.
REQ-030 Requester inputs SHALL be sampled only on a transfer; data changes while not ready are ignored.

Reset
REQ-031 rst_n low SHALL immediately clear FIFO (q_count = 0), rf_we = 0, rf_waddr = 0, rf_wdata = 0, stall_cnt = 0.
REQ-032 While rst_n low, alu_ready = 1 and mem_ready = 1 but no transfer SHALL be recorded.
REQ-033 Reset mid-operation SHALL discard queued entries; no rf_we for them after release.
REQ-034 First transfer SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-035 Load only: mem_valid=1, mem_rd=5, mem_data=32'hDEADBEEF one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF.
REQ-036 ALU only: push rd=3 data=15 -> rf_we=1, waddr=3, wdata=15 two cycles after push; q_count 1 then 0.
REQ-037 Contention: mem_valid held high 4 cycles with ALU pushes rd=1,2 -> loads written first; ALU queue fills to 2, then mem_ready=0, head rd=1 written, stall_cnt=1, order rd=1 before rd=2.
REQ-038 rd=0: ALU push rd=0 data=7 -> alu_ready handshake completes, rf_we stays 0, q_count returns to 0.
REQ-039 Reset mid-operation: queue 2 ALU entries, pulse rst_n low between edges -> q_count=0, rf_we=0, stall_cnt=0 immediately; no writes after release.
REQ-040 Saturation: force 70000 refused load cycles -> stall_cnt = 16'hFFFF, no wrap.
